simdev_initiator: RTL and testbench
===================================

SIMDEV_INITIATOR -- requirements
Module: simdev_initiator

Interface
REQ-001 SHALL have parameter DW, default 8: operand and result width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: request queue entries, power of two, minimum 2.
REQ-003 SHALL have parameter TIMEOUT, default 32: WAIT cycles before an operation is abandoned, minimum 2.
REQ-004 SHALL have port clk  in  1  single clock; all logic updates on the rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  1  request offered.
REQ-007 SHALL have port req_ready  out  1  request queue can accept.
REQ-008 SHALL have port req_a  in  DW  operand A.
REQ-009 SHALL have port req_b  in  DW  operand B.
REQ-010 SHALL have port rsp_valid  out  1  response held for the consumer.
REQ-011 SHALL have port rsp_ready  in  1  consumer accepts the response.
REQ-012 SHALL have port rsp_data  out  DW  result.
REQ-013 SHALL have port rsp_err  out  1  timeout flag for this response.
REQ-014 SHALL have port dev_ena  out  1  start pulse to the adder device.
REQ-015 SHALL have port dev_inA  out  DW  operand A to the device.
REQ-016 SHALL have port dev_inB  out  DW  operand B to the device.
REQ-017 SHALL have port dev_out  in  DW  device result.
REQ-018 SHALL have port dev_ok  in  1  device one-cycle completion pulse.
REQ-019 SHALL have port busy  out  1  high in every state except IDLE.
REQ-020 SHALL have port err_count  out  8  count of timeouts, saturating.

Function
REQ-021 Request queue SHALL be a FIFO_DEPTH FIFO of {req_a, req_b}.
- Push: on req_valid && req_ready.
- req_ready SHALL be !full, registered, and SHALL NOT depend on a same-cycle pop.
- A push and a pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-022 FSM SHALL have the states IDLE, ISSUE, WAIT, RESP, GAP.
REQ-023 IDLE: if the FIFO is non-empty, SHALL pop the head into the operand registers and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-024 ISSUE: dev_ena SHALL be 1 for exactly this one cycle, with dev_inA/dev_inB equal to the popped operands; next state SHALL be WAIT, with the timer cleared to 0.
REQ-025 dev_inA and dev_inB SHALL hold their last issued values outside ISSUE; dev_ena SHALL be 0 in every state except ISSUE.
REQ-026 WAIT: the timer SHALL increment each cycle.
- dev_ok=1: SHALL capture dev_out into rsp_data, set rsp_err=0, and go to RESP.
- Timer reaching TIMEOUT-1 without dev_ok: SHALL set rsp_data=0 and rsp_err=1, increment err_count (saturating at 255), and go to RESP.
- dev_ok and timer=TIMEOUT-1 in the same cycle: dev_ok SHALL win.
REQ-027 RESP: rsp_valid SHALL be 1, with rsp_data and rsp_err stable, until rsp_ready=1; on the handshake, next state SHALL be GAP.
REQ-028 GAP: SHALL last one cycle, so that the device counter settles between operations; next state SHALL be IDLE.
REQ-029 At most one device operation SHALL be outstanding at any time.
REQ-030 dev_ok arriving outside WAIT SHALL be ignored: no state change and no capture.
REQ-031 In RESP, new requests SHALL still be accepted while the FIFO is not full.
REQ-032 Results SHALL be returned in request order; result width SHALL be DW, with any device overflow already truncated.
REQ-033 Back-to-back throughput SHALL be one operation per (device latency + 4) cycles when rsp_ready is held at 1.

Reset
REQ-034 On rst=0, asynchronously:
- FSM SHALL go to IDLE.
- FIFO SHALL be emptied (req_ready=1 after the reset is released).
- rsp_valid, rsp_err, rsp_data, dev_ena, dev_inA, dev_inB, busy, err_count and the timer SHALL all be 0.
REQ-035 Reset asserted during an operation (ISSUE, WAIT or RESP) SHALL discard that operation and every queued request, and SHALL produce no response.
REQ-036 After reset is released, the first possible dev_ena SHALL occur no earlier than the second rising edge.

Verification
REQ-037 Single op: push 0x12/0x34; the device model returns ok 9 cycles after ena -> exactly one dev_ena pulse, rsp_valid with rsp_data=0x46, rsp_err=0.
REQ-038 Overflow: push 0xFF/0x02 -> rsp_data=0x01, rsp_err=0.
REQ-039 Queue fill: hold rsp_ready=0 and push 5 requests -> 1 request issued, 4 queued, req_ready=0; release rsp_ready -> 5 in-order responses, with dev_ena gaps of at least 13 cycles.
REQ-040 Timeout: the device model never asserts ok -> rsp_err=1 and rsp_data=0 exactly TIMEOUT cycles after ISSUE, err_count=1; the next request completes normally.
REQ-041 Stray ok: pulse dev_ok while in IDLE and while in RESP -> no state change and rsp_data unchanged.
REQ-042 Reset mid-WAIT with 2 requests queued -> all outputs 0 and no response; a following request 0x01/0x01 -> rsp_data=0x02.

Source files
------------

// File: rtl/simdev_initiator.sv
// Queued initiator for one adder device: one op in flight, IDLE/ISSUE/WAIT/RESP/GAP, result held until rsp_ready.
// Period is device latency + 4 cycles; req_ready is a registered !full, and WAIT abandons the op after TIMEOUT cycles.
module simdev_initiator #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          dev_ena,
  output logic [DW-1:0] dev_inA,
  output logic [DW-1:0] dev_inB,
  input  logic [DW-1:0] dev_out,
  input  logic          dev_ok,
  output logic          busy,
  output logic [7:0]    err_count
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int TW  = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT   = AW1'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;

  state_t          state_q, state_d;
  logic [2*DW-1:0] mem_q [FIFO_DEPTH];
  logic [2*DW-1:0] head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            req_ready_q, req_ready_d;
  logic [DW-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            push, pop;

  assign push = req_valid && req_ready_q;
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d     = count_q + AW1'(push) - AW1'(pop);
    // Ready follows the occupancy after this edge, never a combinational pop.
    req_ready_d = (count_d != FULL_CNT);
  end

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    timer_d    = timer_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          {op_a_d, op_b_d} = head;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion on the final WAIT cycle still counts as success.
        if (dev_ok) begin
          rsp_data_d = dev_out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (timer_q == TIMER_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d    = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b1;
      op_a_q      <= '0;
      op_b_q      <= '0;
      timer_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      timer_q     <= timer_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Queue storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_a, req_b};
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dev_ena   = (state_q == ISSUE);
  assign dev_inA   = op_a_q;
  assign dev_inB   = op_b_q;
  assign busy      = (state_q != IDLE);
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_simdev_initiator.sv
// Bench for simdev_initiator: latency-programmable adder device model, in-order scoreboard,
// vector table, hand-written corner sequences and a randomized phase.
`timescale 1ns/1ps
module tb_simdev_initiator;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          dev_ena;
  logic [DW-1:0] dev_inA, dev_inB, dev_out;
  logic          dev_ok, busy;
  logic [7:0]    err_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  simdev_initiator #(.DW(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dev_ena(dev_ena), .dev_inA(dev_inA), .dev_inB(dev_inB), .dev_out(dev_out),
    .dev_ok(dev_ok), .busy(busy), .err_count(err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Device: each request carries its own latency (0 = never completes).
  int            dev_lat = 9;
  int            lat_q[$];
  int            dev_cnt = 0;
  logic [DW-1:0] dev_res = '0;
  logic [DW-1:0] dev_pend = '0;
  logic          model_ok = 1'b0;
  logic          stray_ok = 1'b0;
  assign dev_ok  = model_ok | stray_ok;
  assign dev_out = stray_ok ? 8'hA5 : dev_res;

  always @(negedge clk) begin
    model_ok = 1'b0;
    if (!rst) begin
      dev_cnt = 0;
    end else begin
      if (dev_cnt > 0) begin
        dev_cnt--;
        if (dev_cnt == 0) begin
          model_ok = 1'b1;
          dev_res  = dev_pend;
        end
      end
      if (dev_ena) begin
        dev_cnt  = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        dev_pend = dev_inA + dev_inB;
      end
    end
  end

  // Reference model: every accepted request yields one response, in order.
  typedef struct { logic [DW-1:0] data; logic err; } exp_t;
  exp_t exp_q[$];
  int   model_errs = 0;
  int   rsp_seen = 0;
  int   ena_cyc[$];
  int   cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      if (req_valid && req_ready) begin
        exp_t e;
        e.err  = (dev_lat == 0) || (dev_lat > TO);
        e.data = e.err ? '0 : DW'(req_a + req_b);
        exp_q.push_back(e);
        lat_q.push_back(dev_lat);
      end
      if (dev_ena) ena_cyc.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        exp_t e;
        rsp_seen++;
        check("sb_rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e.err && model_errs < 255) model_errs++;
          check("sb_data", rsp_data, e.data);
          check("sb_err", rsp_err, e.err);
          check("sb_err_count", err_count, model_errs);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    model_errs = 0;
  endtask

  task automatic push_req(input logic [DW-1:0] a, input logic [DW-1:0] b, input int lat);
    int n;
    dev_lat = lat; req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (!rsp_valid && n < TO + 40) begin tick(); n++; end
    check({nm, "_rsp_valid"}, rsp_valid, 1);
  endtask

  // One isolated operation: issue timing, result, hold while stalled, then GAP.
  task automatic run_one(input logic [DW-1:0] a, input logic [DW-1:0] b, input int lat,
                         input logic [DW-1:0] ed, input logic ee, input string nm);
    int n, enas;
    push_req(a, b, lat);
    n = 0;
    while (!dev_ena && n < 10) begin tick(); n++; end
    check({nm, "_issue"}, dev_ena, 1);
    check({nm, "_inA"}, dev_inA, a);
    check({nm, "_inB"}, dev_inB, b);
    enas = 0; n = 0;
    while (!rsp_valid && n < TO + 40) begin
      if (dev_ena) enas++;
      tick(); n++;
    end
    // ISSUE cycle, then lat (or TIMEOUT) WAIT cycles, then RESP.
    check({nm, "_delay"}, n, (ee ? TO : lat) + 1);
    check({nm, "_ena_pulses"}, enas, 1);
    check({nm, "_data"}, rsp_data, ed);
    check({nm, "_err"}, rsp_err, ee);
    tick(); tick();
    check({nm, "_hold_valid"}, rsp_valid, 1);
    check({nm, "_hold_data"}, rsp_data, ed);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({nm, "_gap"}, {rsp_valid, busy}, 2'b01);
    tick();
    check({nm, "_idle"}, busy, 0);
  endtask

  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; int lat; logic [DW-1:0] d; logic e; } vec_t;
  vec_t vt[8];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_errs, n, base, cnt_v, cnt_e, sent, got0;
    logic [DW-1:0] prev;
    logic [DW-1:0] fill_exp[5];

    vt[0] = '{8'h12, 8'h34, 9,      8'h46, 1'b0};
    vt[1] = '{8'hFF, 8'h02, 9,      8'h01, 1'b0};
    vt[2] = '{8'h21, 8'h43, 0,      8'h00, 1'b1};
    vt[3] = '{8'h10, 8'h20, 9,      8'h30, 1'b0};
    vt[4] = '{8'h80, 8'h81, TO,     8'h01, 1'b0};
    vt[5] = '{8'h05, 8'h06, TO + 1, 8'h00, 1'b1};
    vt[6] = '{8'h01, 8'h02, 1,      8'h03, 1'b0};
    vt[7] = '{8'hFF, 8'hFF, 3,      8'hFE, 1'b0};

    tick(); tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_dev_ena", dev_ena, 0);
    check("rst_dev_in", {dev_inA, dev_inB}, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b1;
    tick();
    check("post_rst_req_ready", req_ready, 1);

    exp_errs = 0;
    for (int i = 0; i < 8; i++) begin
      run_one(vt[i].a, vt[i].b, vt[i].lat, vt[i].d, vt[i].e, $sformatf("vec%0d", i));
      if (vt[i].e) exp_errs++;
      check($sformatf("vec%0d_err_count", i), err_count, exp_errs);
    end

    // Queue fill with the consumer stalled, then in-order drain at full rate.
    rsp_ready = 1'b0;
    base = ena_cyc.size();
    for (int i = 0; i < 5; i++) begin
      fill_exp[i] = DW'(i * 16 + 3) + DW'(i + 8'h20);
      push_req(DW'(i * 16 + 3), DW'(i + 8'h20), 9);
    end
    check("fill_req_ready_full", req_ready, 0);
    wait_rsp("fill_first");
    tick(); tick();
    check("fill_stalled_ready", req_ready, 0);
    check("fill_issued_once", ena_cyc.size() - base, 1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp($sformatf("fill%0d", k));
      check($sformatf("fill%0d_data", k), rsp_data, fill_exp[k]);
      tick();
    end
    rsp_ready = 1'b0;
    tick(); tick();
    check("fill_ena_total", ena_cyc.size() - base, 5);
    for (int j = 1; j < 5 && base + j < ena_cyc.size(); j++) begin
      n = ena_cyc[base + j] - ena_cyc[base + j - 1];
      check($sformatf("fill_gap%0d_min", j), n >= 13, 1);
      if (j >= 2) check($sformatf("fill_gap%0d", j), n, 13);
    end

    // Stray completions in IDLE and RESP; a request accepted while in RESP.
    prev = rsp_data;
    stray_ok = 1'b1; tick(); stray_ok = 1'b0; tick();
    check("stray_idle_busy", busy, 0);
    check("stray_idle_data", rsp_data, prev);
    push_req(8'h33, 8'h44, 4);
    wait_rsp("stray_op");
    check("stray_op_data", rsp_data, 8'h77);
    check("stray_resp_ready", req_ready, 1);
    dev_lat = 2; req_a = 8'h01; req_b = 8'h0E; req_valid = 1'b1; stray_ok = 1'b1;
    tick();
    req_valid = 1'b0; stray_ok = 1'b0;
    tick();
    check("stray_resp_valid", rsp_valid, 1);
    check("stray_resp_data", rsp_data, 8'h77);
    check("stray_resp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    wait_rsp("resp_push");
    check("resp_push_data", rsp_data, 8'h0F);
    tick();
    rsp_ready = 1'b0;
    tick(); tick();

    // Reset in the middle of WAIT with two requests queued.
    rsp_ready = 1'b1;
    push_req(8'h11, 8'h22, 9);
    push_req(8'h33, 8'h44, 9);
    push_req(8'h55, 8'h66, 9);
    tick(); tick();
    check("midwait_busy", {busy, dev_ena}, 2'b10);
    do_reset();
    #1;
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_data", rsp_data, 0);
    check("arst_rsp_err", rsp_err, 0);
    check("arst_dev_ena", dev_ena, 0);
    check("arst_dev_in", {dev_inA, dev_inB}, 0);
    check("arst_busy", busy, 0);
    check("arst_err_count", err_count, 0);
    tick();
    rst = 1'b1;
    cnt_v = 0; cnt_e = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rsp_valid) cnt_v++;
      if (dev_ena) cnt_e++;
    end
    check("arst_no_rsp", cnt_v, 0);
    check("arst_no_issue", cnt_e, 0);
    check("arst_req_ready", req_ready, 1);

    // Request offered across reset release: no issue on the first edge.
    do_reset();
    dev_lat = 9; req_a = 8'h01; req_b = 8'h01; req_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    req_valid = 1'b0;
    check("first_edge_no_ena", dev_ena, 0);
    wait_rsp("post_rst_op");
    check("post_rst_op_data", rsp_data, 8'h02);
    check("post_rst_op_err", rsp_err, 0);
    tick();
    rsp_ready = 1'b0;
    tick(); tick();

    // Randomized traffic against the scoreboard.
    do_reset();
    tick();
    rst = 1'b1;
    tick();
    sent = 0;
    got0 = rsp_seen;
    for (int c = 0; c < 20000 && sent < 30; c++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_a     = DW'($urandom);
      req_b     = DW'($urandom);
      dev_lat   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 2));
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (req_valid && req_ready) sent++;
      tick();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 5000 && (exp_q.size() > 0 || busy); c++) begin
      rsp_ready = ($urandom_range(0, 1) != 0);
      tick();
    end
    rsp_ready = 1'b0;
    tick();
    check("rand_sent", sent, 30);
    check("rand_drained", exp_q.size(), 0);
    check("rand_rsp_count", rsp_seen - got0, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
